// File: rtl/mult_dot_acc_if.sv
// Handshake bundle for the dot-product stage: operand pairs in, product
// loop to/from the external multiplier, and the summed result out.
interface mult_dot_acc_if #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 2*WIDTH+2
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_a;
  logic [WIDTH-1:0]       in_b;
  logic [WIDTH-1:0]       mult_a;
  logic [WIDTH-1:0]       mult_b;
  logic [2*WIDTH-1:0]     mult_y;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_WIDTH-1:0]   out_sum;
  logic                   out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, mult_y, out_ready,
    output in_ready, mult_a, mult_b, out_valid, out_sum, out_ovf
  );
  modport master (
    output in_valid, in_a, in_b, mult_y, out_ready,
    input  in_ready, mult_a, mult_b, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/mult_dot_acc.sv
// Sequential dot-product stage: registers operand pairs into an external
// combinational multiplier and accumulates LEN products per result.
module mult_dot_acc #(
  parameter int WIDTH     = 4,
  parameter int LEN       = 4,
  parameter int ACC_WIDTH = 2*WIDTH+2
) (
  input  logic            clk,
  input  logic            rst_n,
  mult_dot_acc_if.slave   bus
);
  localparam int CW = $clog2(LEN+1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]           state;
  logic [CW-1:0]        acnt;
  logic                 run;
  logic                 op_vld;
  logic                 op_last;
  logic                 op_first;
  logic                 ovf;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]   sum_ext;
  logic                 accept;
  logic                 last_acc;
  logic                 out_hs;

  // run holds in_ready low during reset and for the edge it is released on
  assign bus.in_ready = run && (acnt < CW'(LEN)) && !bus.out_valid;
  assign accept       = bus.in_valid && bus.in_ready;
  assign last_acc     = (acnt == CW'(LEN-1));
  assign out_hs       = bus.out_valid && bus.out_ready;
  assign sum_ext      = (op_first ? '0 : {1'b0, acc}) + (ACC_WIDTH+1)'(bus.mult_y);
  assign bus.out_sum  = acc;
  assign bus.out_ovf  = ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run           <= 1'b0;
      acnt          <= '0;
      op_vld        <= 1'b0;
      op_last       <= 1'b0;
      op_first      <= 1'b0;
      bus.mult_a    <= '0;
      bus.mult_b    <= '0;
      acc           <= '0;
      ovf           <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      run    <= 1'b1;
      op_vld <= accept;
      if (accept) begin
        bus.mult_a <= bus.in_a;
        bus.mult_b <= bus.in_b;
        op_last    <= last_acc;
        op_first   <= (acnt == '0);
        acnt       <= acnt + CW'(1);
      end
      // product of the pair registered last edge is on mult_y now
      if (op_vld) begin
        acc <= sum_ext[ACC_WIDTH-1:0];
        ovf <= (op_first ? 1'b0 : ovf) | sum_ext[ACC_WIDTH];
        if (op_last) bus.out_valid <= 1'b1;
      end
      if (out_hs) begin
        bus.out_valid <= 1'b0;
        acnt          <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state <= (LEN == 1) ? DRAIN : FILL;
        FILL:    if (accept && last_acc) state <= DRAIN;
        DRAIN:   if (op_vld && op_last) state <= DONE;
        DONE:    if (out_hs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_dot_acc.sv
// Directed and randomized checks of the dot-product stage with a behavioural
// multiplier; a 9-bit accumulator copy shares stimulus to exercise wraparound.
module tb_mult_dot_acc;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_a, in_b;
  logic       out_ready;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  mult_dot_acc_if #(.WIDTH(4), .ACC_WIDTH(10)) b10 ();
  mult_dot_acc_if #(.WIDTH(4), .ACC_WIDTH(9))  b9 ();

  assign b10.in_valid  = in_valid;
  assign b10.in_a      = in_a;
  assign b10.in_b      = in_b;
  assign b10.out_ready = out_ready;
  assign b10.mult_y    = 8'(b10.mult_a) * 8'(b10.mult_b);
  assign b9.in_valid   = in_valid;
  assign b9.in_a       = in_a;
  assign b9.in_b       = in_b;
  assign b9.out_ready  = out_ready;
  assign b9.mult_y     = 8'(b9.mult_a) * 8'(b9.mult_b);

  mult_dot_acc #(.WIDTH(4), .LEN(4), .ACC_WIDTH(10)) dut10 (.clk(clk), .rst_n(rst_n), .bus(b10.slave));
  mult_dot_acc #(.WIDTH(4), .LEN(4), .ACC_WIDTH(9))  dut9  (.clk(clk), .rst_n(rst_n), .bus(b9.slave));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // holds in_valid until accepted, then drops it right after the accept edge
  task automatic send(input int a, input int b);
    int n = 0;
    in_a = a[3:0]; in_b = b[3:0]; in_valid = 1'b1;
    while (!b10.in_ready && n < 50) begin tick(); n++; end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL send_timeout: in_ready=%0d required 1", b10.in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output bit ok);
    int n = 0;
    while (!b10.out_valid && n < 30) begin tick(); n++; end
    ok = b10.out_valid;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL result_timeout: out_valid=%0d required 1", b10.out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_a = 4'd0; in_b = 4'd0; out_ready = 1'b1;
    #1;
    checks++; if (b10.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %0d required 0", b10.in_ready); end
    repeat (3) tick();
    checks++; if (b10.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0d required 0", b10.out_valid); end
    checks++; if (b10.out_sum !== 10'd0) begin failures++; $display("FAIL reset_out_sum: got %0d required 0", b10.out_sum); end
    checks++; if (b10.in_ready !== 1'b0) begin failures++; $display("FAIL reset_hold_in_ready: got %0d required 0", b10.in_ready); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    checks++; if (b10.in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready: got %0d required 1", b10.in_ready); end
  endtask

  task automatic test_basic();
    send(1, 2); send(3, 4); send(5, 6); send(7, 8);
    checks++; if (b10.out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_e1: got %0d required 0", b10.out_valid); end
    checks++; if (b10.in_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_full: got %0d required 0", b10.in_ready); end
    tick();
    checks++; if (b10.out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid_e2: got %0d required 1", b10.out_valid); end
    checks++; if (b10.out_sum !== 10'd100) begin failures++; $display("FAIL basic_sum: got %0d required 100", b10.out_sum); end
    checks++; if (b10.out_ovf !== 1'b0) begin failures++; $display("FAIL basic_ovf: got %0d required 0", b10.out_ovf); end
    tick();
    checks++; if (b10.out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_one_cycle: got %0d required 0", b10.out_valid); end
    checks++; if (b10.in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_after: got %0d required 1", b10.in_ready); end
  endtask

  task automatic test_overflow();
    bit ok;
    repeat (4) send(15, 15);
    wait_result(ok);
    checks++; if (b10.out_sum !== 10'd900) begin failures++; $display("FAIL ovf_sum10: got %0d required 900", b10.out_sum); end
    checks++; if (b10.out_ovf !== 1'b0) begin failures++; $display("FAIL ovf_flag10: got %0d required 0", b10.out_ovf); end
    checks++; if (b9.out_sum !== 9'd388) begin failures++; $display("FAIL ovf_sum9: got %0d required 388", b9.out_sum); end
    checks++; if (b9.out_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag9: got %0d required 1", b9.out_ovf); end
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    out_ready = 1'b0;
    repeat (4) send(2, 2);
    wait_result(ok);
    for (int i = 0; i < 5; i++) begin
      in_a = 4'd9; in_b = 4'd9; in_valid = 1'b1;
      checks++; if (b10.out_sum !== 10'd16) begin failures++; $display("FAIL bp_sum_hold: got %0d required 16", b10.out_sum); end
      checks++; if (b10.out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_hold: got %0d required 1", b10.out_valid); end
      checks++; if (b10.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %0d required 0", b10.in_ready); end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (b10.out_valid !== 1'b0) begin failures++; $display("FAIL bp_release: got %0d required 0", b10.out_valid); end
    repeat (4) send(1, 1);
    wait_result(ok);
    checks++; if (b10.out_sum !== 10'd4) begin failures++; $display("FAIL bp_next_sum: got %0d required 4", b10.out_sum); end
    tick();
  endtask

  task automatic test_gaps();
    bit ok;
    int gaps[4] = '{1, 3, 2, 1};
    int as[4]   = '{1, 3, 5, 7};
    int bs[4]   = '{2, 4, 6, 8};
    for (int i = 0; i < 4; i++) begin
      repeat (gaps[i]) tick();
      send(as[i], bs[i]);
    end
    checks++; if (b10.in_ready !== 1'b0) begin failures++; $display("FAIL gaps_ready: got %0d required 0", b10.in_ready); end
    wait_result(ok);
    checks++; if (b10.out_sum !== 10'd100) begin failures++; $display("FAIL gaps_sum: got %0d required 100", b10.out_sum); end
    tick();
  endtask

  task automatic test_mid_reset();
    bit ok;
    send(5, 6); send(7, 8);
    rst_n = 1'b0;
    #1;
    checks++; if (b10.mult_a !== 4'd0 || b10.mult_b !== 4'd0) begin failures++; $display("FAIL mrst_mult: got %0d,%0d required 0,0", b10.mult_a, b10.mult_b); end
    checks++; if (b10.in_ready !== 1'b0) begin failures++; $display("FAIL mrst_in_ready: got %0d required 0", b10.in_ready); end
    checks++; if (b10.out_valid !== 1'b0 || b10.out_ovf !== 1'b0) begin failures++; $display("FAIL mrst_out: got %0d,%0d required 0,0", b10.out_valid, b10.out_ovf); end
    checks++; if (b10.out_sum !== 10'd0) begin failures++; $display("FAIL mrst_sum: got %0d required 0", b10.out_sum); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    repeat (4) send(2, 3);
    wait_result(ok);
    checks++; if (b10.out_sum !== 10'd24) begin failures++; $display("FAIL mrst_next_sum: got %0d required 24", b10.out_sum); end
    tick();
  endtask

  task automatic test_random();
    bit ok;
    for (int v = 0; v < 1000; v++) begin
      int s = 0;
      for (int i = 0; i < 4; i++) begin
        int a = $urandom_range(0, 15);
        int b = $urandom_range(0, 15);
        repeat ($urandom_range(0, 1)) tick();
        send(a, b);
        s += a * b;
      end
      out_ready = 1'($urandom_range(0, 1));
      wait_result(ok);
      while (ok && !out_ready) begin tick(); out_ready = 1'($urandom_range(0, 1)); end
      checks++; if (b10.out_sum !== 10'(s)) begin failures++; $display("FAIL rand_sum10 v%0d: got %0d required %0d", v, b10.out_sum, s); end
      checks++; if (b9.out_sum !== 9'(s % 512) || b9.out_ovf !== (s >= 512)) begin failures++; $display("FAIL rand_sum9 v%0d: got %0d/%0d required %0d/%0d", v, b9.out_sum, b9.out_ovf, s % 512, s >= 512); end
      tick();
      checks++; if (b10.out_valid !== 1'b0) begin failures++; $display("FAIL rand_valid_drop v%0d: got %0d required 0", v, b10.out_valid); end
    end
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_gaps();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
